// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : shared types, key codes and column/row helpers for keypad_scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_LOAD     = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  localparam logic [3:0] KEY_RIGHT = 4'b1111;
  localparam logic [3:0] KEY_LEFT  = 4'b1101;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-index active-low row wins when several keys share a column.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_sync.sv
// ---------------------------------------------------------------------------
// row_sync : 4-bit two-flop synchronizer, resets to the idle (all-high) level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_async,
  output logic [3:0] row_synced
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_synced = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner : 4x4 column-scanned keypad with press/release debounce
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       left_right,
  output logic       key_valid
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [3:0] row_s;
  logic       pressed;

  row_sync u_row_sync (
    .clk        (clk),
    .reset      (reset),
    .row_async  (row),
    .row_synced (row_s)
  );

  assign pressed = (row_s != ROW_IDLE);

  state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [3:0] col_q, col_d;
  logic [3:0] cap_row_q, cap_row_d;
  logic [3:0] cap_code_q, cap_code_d;
  logic [3:0] value_q, value_d;
  logic       lr_q, lr_d;
  logic       kv_q, kv_d;

  // One counter serves as scan dwell, press debounce and release debounce.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_idx_d  = col_idx_q;
    cap_row_d  = cap_row_q;
    cap_code_d = cap_code_q;
    value_d    = value_q;
    lr_d       = lr_q;
    kv_d       = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (pressed) begin
            cap_row_d  = row_s;
            cap_code_d = {row_index(row_s), col_idx_q};
            state_d    = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s != cap_row_q) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else if (cnt_q == DEB_LAST) begin
          // Code is published on LOAD entry so it leads the left_right edge.
          cnt_d   = '0;
          value_d = cap_code_q;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        lr_d    = 1'b1;
        kv_d    = 1'b1;
        state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!pressed) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (pressed) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d     = '0;
          lr_d      = 1'b0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        lr_d    = 1'b0;
        state_d = ST_SCAN;
      end
    endcase
    col_d = col_drive(col_idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SCAN;
      cnt_q      <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      cap_row_q  <= ROW_IDLE;
      cap_code_q <= 4'b0000;
      value_q    <= 4'b0000;
      lr_q       <= 1'b0;
      kv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      cap_row_q  <= cap_row_d;
      cap_code_q <= cap_code_d;
      value_q    <= value_d;
      lr_q       <= lr_d;
      kv_q       <= kv_d;
    end
  end

  assign col        = col_q;
  assign value      = value_q;
  assign left_right = lr_q;
  assign key_valid  = kv_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner : directed self-checking bench, SCAN_DIV=4, DEBOUNCE_CNT=8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] value;
  logic       left_right;
  logic       key_valid;

  // Keypad model: the pressed key pulls its rows low only while its column is driven.
  logic       key_on   = 1'b0;
  logic       glitch   = 1'b0;
  logic [1:0] key_col  = 2'd0;
  logic [3:0] key_rows = 4'b1111;
  logic [3:0] key_drv;

  always_comb key_drv = ~(4'b0001 << key_col);
  assign row = (key_on && !glitch && (col == key_drv)) ? key_rows : 4'b1111;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .value      (value),
    .left_right (left_right),
    .key_valid  (key_valid)
  );

  task automatic wait_col(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (col === c) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_col_not(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (col !== c) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Sample 0 is the first negedge with the key's column driven.
  task automatic measure_press(input logic [3:0] exp_val, input logic [3:0] exp_col, input string name);
    bit         early;
    logic       lr13, kv13;
    logic [3:0] v12;
    int         extra;
    early = 1'b0; lr13 = 1'b0; kv13 = 1'b0; v12 = 4'h0; extra = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n < 13 && left_right) early = 1'b1;
      if (n == 12) v12 = value;
      if (n == 13) begin
        lr13 = left_right;
        kv13 = key_valid;
      end
      if (n > 13 && key_valid) extra++;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL %s_early_edge: got %b expected 0", name, early); end
    checks++; if (lr13 !== 1'b1) begin failures++; $display("FAIL %s_lr_rise: got %b expected 1", name, lr13); end
    checks++; if (kv13 !== 1'b1) begin failures++; $display("FAIL %s_kv_pulse: got %b expected 1", name, kv13); end
    checks++; if (v12 !== exp_val) begin failures++; $display("FAIL %s_value_lead: got %b expected %b", name, v12, exp_val); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL %s_extra_kv: got %0d expected 0", name, extra); end
    checks++; if (left_right !== 1'b1) begin failures++; $display("FAIL %s_lr_held: got %b expected 1", name, left_right); end
    checks++; if (col !== exp_col) begin failures++; $display("FAIL %s_col_frozen: got %b expected %b", name, col, exp_col); end
  endtask

  task automatic press(input logic [1:0] kc, input logic [3:0] kr, input logic [3:0] exp_val, input string name);
    bit ok1, ok2;
    logic [3:0] drv;
    drv = ~(4'b0001 << kc);
    wait_col_not(drv, ok1);
    key_col = kc; key_rows = kr; key_on = 1'b1;
    wait_col(drv, ok2);
    checks++;
    if (!(ok1 && ok2)) begin failures++; $display("FAIL %s_wait_col: got timeout expected col %b", name, drv); end
    measure_press(exp_val, drv, name);
  endtask

  task automatic release_measure(input logic [3:0] exp_col, input logic [3:0] exp_val, input string name);
    int fall, kvs;
    logic [3:0] col_f;
    fall = 0; kvs = 0; col_f = 4'h0;
    key_on = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (key_valid) kvs++;
      if (!left_right && fall == 0) begin
        fall  = n;
        col_f = col;
      end
    end
    checks++; if (fall !== 11) begin failures++; $display("FAIL %s_fall_time: got %0d expected 11", name, fall); end
    checks++; if (col_f !== exp_col) begin failures++; $display("FAIL %s_next_col: got %b expected %b", name, col_f, exp_col); end
    checks++; if (kvs !== 0) begin failures++; $display("FAIL %s_release_kv: got %0d expected 0", name, kvs); end
    checks++; if (value !== exp_val) begin failures++; $display("FAIL %s_value_kept: got %b expected %b", name, value, exp_val); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++; if (value !== 4'b0000) begin failures++; $display("FAIL reset_value: got %b expected 0000", value); end
    checks++; if (left_right !== 1'b0) begin failures++; $display("FAIL reset_lr: got %b expected 0", left_right); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_kv: got %b expected 0", key_valid); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] seq [4];
    bit outs_hi;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    outs_hi = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (col !== seq[i/4]) begin failures++; $display("FAIL idle_col[%0d]: got %b expected %b", i, col, seq[i/4]); end
      if (left_right || key_valid) outs_hi = 1'b1;
      @(negedge clk);
    end
    checks++; if (outs_hi !== 1'b0) begin failures++; $display("FAIL idle_outputs: got %b expected 0", outs_hi); end
  endtask

  task automatic test_right_key();
    press(2'd3, 4'b0111, 4'b1111, "right");
    release_measure(4'b1110, 4'b1111, "right_rel");
  endtask

  task automatic test_bounce_left();
    bit ok1, ok2;
    bit seen;
    seen = 1'b0;
    wait_col_not(4'b1101, ok1);
    key_col = 2'd1; key_rows = 4'b0111; key_on = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_col(4'b1101, ok2);
      checks++;
      if (!ok2) begin failures++; $display("FAIL bounce_wait[%0d]: got timeout expected col 1101", g); end
      for (int n = 1; n <= 7; n++) begin
        @(negedge clk);
        if (left_right || key_valid) seen = 1'b1;
      end
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
      wait_col_not(4'b1101, ok2);
      checks++;
      if (!ok2) begin failures++; $display("FAIL bounce_abort[%0d]: got col stuck expected scan resume", g); end
      if (left_right || key_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL bounce_no_edge: got %b expected 0", seen); end
    wait_col(4'b1101, ok2);
    checks++;
    if (!(ok1 && ok2)) begin failures++; $display("FAIL bounce_final_wait: got timeout expected col 1101"); end
    measure_press(4'b1101, 4'b1101, "left");
  endtask

  task automatic test_release_repress();
    bit drop;
    int kvs;
    drop = 1'b0; kvs = 0;
    key_on = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!left_right) drop = 1'b1;
      if (key_valid) kvs++;
      if (n == 6) key_on = 1'b1;
      if (n == 8) key_on = 1'b0;
    end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL repress_lr_drop: got %b expected 0", drop); end
    checks++; if (kvs !== 0) begin failures++; $display("FAIL repress_kv: got %0d expected 0", kvs); end
    release_measure(4'b1011, 4'b1101, "repress_rel");
  endtask

  task automatic test_multi_row();
    press(2'd0, 4'b0101, 4'b0100, "multi");
    release_measure(4'b1101, 4'b0100, "multi_rel");
  endtask

  task automatic test_reset_held();
    int kvs;
    kvs = 0;
    press(2'd2, 4'b1110, 4'b0010, "pre_rst");
    #2 reset = 1'b0;
    #1;
    checks++; if (left_right !== 1'b0) begin failures++; $display("FAIL rst_held_lr: got %b expected 0", left_right); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_held_kv: got %b expected 0", key_valid); end
    checks++; if (value !== 4'b0000) begin failures++; $display("FAIL rst_held_value: got %b expected 0000", value); end
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL rst_held_col: got %b expected 1110", col); end
    @(negedge clk);
    key_on = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (col !== 4'b1110) begin failures++; $display("FAIL rst_resume_col[%0d]: got %b expected 1110", i, col); end
      if (key_valid) kvs++;
      @(negedge clk);
    end
    for (int i = 0; i < 12; i++) begin
      if (key_valid || left_right) kvs++;
      @(negedge clk);
    end
    checks++; if (kvs !== 0) begin failures++; $display("FAIL rst_no_kv: got %0d expected 0", kvs); end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_idle_scan();
    test_right_key();
    test_bounce_left();
    test_release_repress();
    test_multi_row();
    test_reset_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
